arm_mul_unit: RTL

Iterative 32x32 multiplier implementing ARM MUL/MLA (low 32 bits of the product) for the datapath. It sits directly upstream of the flag register. It drives the Z, C, N, V and ENABLE inputs of the flag register with the S-bit-qualified flags of each completed multiply. It drives RESULT to the register-file write-back mux. It is a radix-2 shift-and-add unit with a START/BUSY/DONE handshake.

---
 rtl/arm_pkg.sv | 20 ++
 rtl/mul_flag_gen.sv | 28 ++
 rtl/arm_mul_unit.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/arm_pkg.sv
// arm_pkg: shared definitions for the ARM datapath blocks.
//   mul_state_t : state encoding of the iterative multiplier (IDLE/RUN/FIN)
//   MUL_ITER    : number of radix-2 iterations for a full 32-bit multiplier
//   FLAG_*      : bit positions of Z/C/N/V in the flag register Q vector
package arm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } mul_state_t;

  localparam int MUL_ITER = 32;

  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/mul_flag_gen.sv
// mul_flag_gen: derives N and Z from a result word and passes C and V
// through unchanged, packed in flag register order (FLAG_* indices).
// Reusable by the ALU flag path.
// Ports:
//   value    in  WIDTH  result word
//   carry    in  1      carry to pass through
//   overflow in  1      overflow to pass through
//   flags    out 4      {Z,C,N,V} at FLAG_Z/FLAG_C/FLAG_N/FLAG_V
module mul_flag_gen
  import arm_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] value,
  input  logic             carry,
  input  logic             overflow,
  output logic [3:0]       flags
);

  always_comb begin
    flags         = '0;
    flags[FLAG_Z] = (value == '0);
    flags[FLAG_N] = value[WIDTH-1];
    flags[FLAG_C] = carry;
    flags[FLAG_V] = overflow;
  end

endmodule

// File: rtl/arm_mul_unit.sv
// arm_mul_unit: iterative radix-2 shift-and-add multiplier for ARM MUL/MLA.
// Produces the low 32 bits of A*B (MUL) or A*B+ACC (MLA), plus the
// S-qualified flags for the flag register. C and V pass through unchanged.
// Optional build macro: MUL_EARLY_TERM_EN -- when defined, RUN exits as soon
// as the remaining multiplier bits are zero (data-dependent latency);
// otherwise RUN always takes MUL_ITER cycles.
// Ports:
//   CLK, RESET_N        clock, asynchronous active-low reset
//   START               request, accepted only in IDLE
//   A, B, ACC           multiplicand, multiplier, accumulate operand
//   ACCUM, S            MLA select, set-flags bit
//   C_IN, V_IN          current C/V from the flag register
//   RESULT              registered result, held until the next completion
//   BUSY, DONE          busy while in RUN, one-cycle completion pulse
//   Z, C, N, V, FLAG_EN registered flags and flag register enable
module arm_mul_unit
  import arm_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] ACC,
  input  logic             ACCUM,
  input  logic             S,
  input  logic             C_IN,
  input  logic             V_IN,
  output logic [WIDTH-1:0] RESULT,
  output logic             BUSY,
  output logic             DONE,
  output logic             Z,
  output logic             C,
  output logic             N,
  output logic             V,
  output logic             FLAG_EN
);

  localparam int CNT_W = $clog2(MUL_ITER);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MUL_ITER - 1);

  mul_state_t state, state_next;

  logic [WIDTH-1:0] mcand, mplier, prod;
  logic [WIDTH-1:0] mcand_next, mplier_next, prod_next;
  logic [CNT_W-1:0] cnt;
  logic             s_q, c_q, v_q;
  logic             last_iter;
  logic [WIDTH-1:0] result_q;
  logic [3:0]       flags_q;
  logic [3:0]       flags_next;

  // One shift-and-add step; the sum wraps, discarding bits above 32.
  always_comb begin
    prod_next   = mplier[0] ? (prod + mcand) : prod;
    mcand_next  = mcand << 1;
    mplier_next = mplier >> 1;
`ifdef MUL_EARLY_TERM_EN
    last_iter   = (cnt == LAST_CNT) || (mplier_next == '0);
`else
    last_iter   = (cnt == LAST_CNT);
`endif
  end

  // Flags are computed from the value about to be written into RESULT so
  // both land in their registers on the edge that enters FIN.
  mul_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
    .value    (prod_next),
    .carry    (c_q),
    .overflow (v_q),
    .flags    (flags_next)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (START) state_next = RUN;
      RUN:     if (last_iter) state_next = FIN;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state <= IDLE;
    else          state <= state_next;
  end

  // Operands are captured only on the accepting edge; later changes to the
  // inputs cannot disturb an operation in flight.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      mcand    <= '0;
      mplier   <= '0;
      prod     <= '0;
      cnt      <= '0;
      s_q      <= 1'b0;
      c_q      <= 1'b0;
      v_q      <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (START) begin
            mcand  <= A;
            mplier <= B;
            prod   <= ACCUM ? ACC : '0;
            cnt    <= '0;
            s_q    <= S;
            c_q    <= C_IN;
            v_q    <= V_IN;
          end
        end
        RUN: begin
          prod   <= prod_next;
          mcand  <= mcand_next;
          mplier <= mplier_next;
          cnt    <= cnt + 1'b1;
          if (last_iter) begin
            result_q <= prod_next;
            flags_q  <= flags_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign RESULT  = result_q;
  assign Z       = flags_q[FLAG_Z];
  assign C       = flags_q[FLAG_C];
  assign N       = flags_q[FLAG_N];
  assign V       = flags_q[FLAG_V];
  assign BUSY    = (state == RUN);
  assign DONE    = (state == FIN);
  assign FLAG_EN = DONE & s_q;

endmodule
